// File: rtl/switch_cfg_pkg.sv
// Shared definitions for the crosspoint switch configuration controller:
// table geometry, host op codes, controller states and the identity route map.
package switch_cfg_pkg;

    localparam int N_PORTS = 16;
    localparam int SEL_W   = 4;
    localparam int TBL_W   = N_PORTS * SEL_W;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_COMMIT = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_RSVD   = 2'b11
    } cfg_op_t;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        CLEAR       = 2'b01,
        COMMIT_WAIT = 2'b10
    } cfg_state_t;

    // Entry k routes input k to output k.
    localparam logic [TBL_W-1:0] IDENTITY_TBL = 64'hFEDC_BA98_7654_3210;

endpackage

// File: rtl/sel_table.sv
// 16-entry route table: single-entry write port, whole-table parallel load,
// identity contents after reset, flat output with entry k at bits [4k+3:4k].
module sel_table
    import switch_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [SEL_W-1:0] waddr,
    input  logic [SEL_W-1:0] wdata,
    input  logic             ld,
    input  logic [TBL_W-1:0] ld_data,
    output logic [TBL_W-1:0] tbl
);

    // A whole-table load takes precedence over a single-entry write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl <= IDENTITY_TBL;
        end else if (ld) begin
            tbl <= ld_data;
        end else if (we) begin
            tbl[waddr*SEL_W +: SEL_W] <= wdata;
        end
    end

endmodule

// File: rtl/switch_cfg_ctrl.sv
// Crosspoint switch configuration controller: host edits a shadow route table,
// COMMIT copies it to the active table on a frame boundary. Optional readback
// ports are enabled by defining SWCFG_READBACK_EN.
module switch_cfg_ctrl
    import switch_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_op,
    input  logic [SEL_W-1:0] cfg_out,
    input  logic [SEL_W-1:0] cfg_in,
    input  logic             frame_sync,
    output logic [TBL_W-1:0] sel_flat,
    output logic             commit_done,
    output logic             busy
`ifdef SWCFG_READBACK_EN
    ,
    input  logic [SEL_W-1:0] rd_idx,
    output logic [SEL_W-1:0] rd_shadow,
    output logic [SEL_W-1:0] rd_active
`endif
);

    cfg_state_t       state, state_nxt;
    logic [SEL_W-1:0] clr_cnt;
    logic             shadow_we;
    logic [SEL_W-1:0] shadow_waddr;
    logic [SEL_W-1:0] shadow_wdata;
    logic             active_ld;
    logic             accept;
    logic [TBL_W-1:0] shadow_flat;

    assign accept = cfg_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clr_cnt     <= '0;
            commit_done <= 1'b0;
        end else begin
            state       <= state_nxt;
            commit_done <= active_ld;
            // Counter rests at 0 outside CLEAR and wraps back to 0 on the last entry.
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        shadow_we    = 1'b0;
        shadow_waddr = cfg_out;
        shadow_wdata = cfg_in;
        active_ld    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cfg_op_t'(cfg_op))
                        OP_WRITE:  shadow_we = 1'b1;
                        OP_COMMIT: begin
                            if (frame_sync) begin
                                active_ld = 1'b1;
                            end else begin
                                state_nxt = COMMIT_WAIT;
                            end
                        end
                        OP_CLEAR:  state_nxt = CLEAR;
                        default:   ;
                    endcase
                end
            end
            CLEAR: begin
                shadow_we    = 1'b1;
                shadow_waddr = clr_cnt;
                shadow_wdata = clr_cnt;
                if (clr_cnt == SEL_W'(N_PORTS - 1)) begin
                    state_nxt = IDLE;
                end
            end
            COMMIT_WAIT: begin
                if (frame_sync) begin
                    active_ld = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    sel_table u_shadow (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (shadow_we),
        .waddr   (shadow_waddr),
        .wdata   (shadow_wdata),
        .ld      (1'b0),
        .ld_data ({TBL_W{1'b0}}),
        .tbl     (shadow_flat)
    );

    // Active table only ever changes by a full copy, so the matrix never sees a partial map.
    sel_table u_active (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (1'b0),
        .waddr   ({SEL_W{1'b0}}),
        .wdata   ({SEL_W{1'b0}}),
        .ld      (active_ld),
        .ld_data (shadow_flat),
        .tbl     (sel_flat)
    );

`ifdef SWCFG_READBACK_EN
    assign rd_shadow = shadow_flat[rd_idx*SEL_W +: SEL_W];
    assign rd_active = sel_flat[rd_idx*SEL_W +: SEL_W];
`endif

endmodule

// File: tb/tb_switch_cfg_ctrl.sv
// Bench for switch_cfg_ctrl: directed scenarios followed by random traffic,
// all checked against a route-map model kept as plain arrays.
module tb_switch_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_op = 2'b00;
    logic [3:0]  cfg_out = 4'd0;
    logic [3:0]  cfg_in = 4'd0;
    logic        frame_sync = 1'b0;
    logic [63:0] sel_flat;
    logic        commit_done;
    logic        busy;
`ifdef SWCFG_READBACK_EN
    logic [3:0]  rd_idx = 4'd0;
    logic [3:0]  rd_shadow;
    logic [3:0]  rd_active;
`endif

    switch_cfg_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_op      (cfg_op),
        .cfg_out     (cfg_out),
        .cfg_in      (cfg_in),
        .frame_sync  (frame_sync),
        .sel_flat    (sel_flat),
        .commit_done (commit_done),
        .busy        (busy)
`ifdef SWCFG_READBACK_EN
        ,
        .rd_idx      (rd_idx),
        .rd_shadow   (rd_shadow),
        .rd_active   (rd_active)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: route tables, cycles of clearing left, commit pending flag.
    int m_shadow [16];
    int m_active [16];
    int m_clear_left;
    bit m_pending;
    bit m_done;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] flat(input int t [16]);
        logic [63:0] f;
        f = '0;
        for (int k = 0; k < 16; k++) f[k*4 +: 4] = 4'(t[k]);
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            m_shadow[k] = k;
            m_active[k] = k;
        end
        m_clear_left = 0;
        m_pending    = 1'b0;
        m_done       = 1'b0;
    endtask

    // One clock: update the model from the pre-edge inputs, then compare outputs just after the edge.
    task automatic tick();
        bit idle;
        idle   = (m_clear_left == 0) && !m_pending;
        m_done = 1'b0;
        if (m_clear_left > 0) begin
            m_shadow[16 - m_clear_left] = 16 - m_clear_left;
            m_clear_left--;
        end else if (m_pending) begin
            if (frame_sync) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
                m_done    = 1'b1;
            end
        end else if (idle && cfg_valid) begin
            case (cfg_op)
                2'b00: m_shadow[cfg_out] = cfg_in;
                2'b01: begin
                    if (frame_sync) begin
                        m_active = m_shadow;
                        m_done   = 1'b1;
                    end else begin
                        m_pending = 1'b1;
                    end
                end
                2'b10: m_clear_left = 16;
                default: ;
            endcase
        end
`ifdef SWCFG_READBACK_EN
        rd_idx = 4'($urandom_range(0, 15));
`endif
        @(posedge clk);
        #1;
        idle = (m_clear_left == 0) && !m_pending;
        chk("sel_flat", sel_flat, flat(m_active));
        chk("cfg_ready", 64'(cfg_ready), 64'(idle));
        chk("busy", 64'(busy), 64'(!idle));
        chk("commit_done", 64'(commit_done), 64'(m_done));
`ifdef SWCFG_READBACK_EN
        chk("rd_shadow", 64'(rd_shadow), 64'(m_shadow[rd_idx]));
        chk("rd_active", 64'(rd_active), 64'(m_active[rd_idx]));
`endif
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] o, input logic [3:0] i, input logic fs);
        cfg_valid  = 1'b1;
        cfg_op     = op;
        cfg_out    = o;
        cfg_in     = i;
        frame_sync = fs;
        tick();
        cfg_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    initial begin
        int lowcnt;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_sel", sel_flat, 64'hFEDC_BA98_7654_3210);
        chk("rst_ready", 64'(cfg_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(commit_done), 64'd0);
        rst_n = 1'b1;
        tick();

        // Writes, then commit that waits five cycles for the frame strobe
        cmd(2'b00, 4'd3, 4'd9, 1'b0);
        cmd(2'b00, 4'd0, 4'd15, 1'b0);
        cmd(2'b01, 4'd0, 4'd0, 1'b0);
        repeat (5) tick();
        chk("wait_busy", 64'(busy), 64'd1);
        chk("wait_sel_unchanged", sel_flat, 64'hFEDC_BA98_7654_3210);
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("nibble3", 64'(sel_flat[15:12]), 64'd9);
        chk("nibble0", 64'(sel_flat[3:0]), 64'd15);
        chk("done_pulse", 64'(commit_done), 64'd1);
        tick();
        chk("done_single", 64'(commit_done), 64'd0);

        // Commit with the strobe in the accept cycle
        cmd(2'b00, 4'd7, 4'd1, 1'b0);
        cmd(2'b01, 4'd0, 4'd0, 1'b1);
        chk("imm_ready", 64'(cfg_ready), 64'd1);
        chk("imm_nibble7", 64'(sel_flat[31:28]), 64'd1);

        // Clear with a write held pending throughout
        cmd(2'b10, 4'd0, 4'd0, 1'b0);
        lowcnt = 1;
        cfg_valid = 1'b1;
        cfg_op    = 2'b00;
        cfg_out   = 4'd5;
        cfg_in    = 4'd2;
        for (int n = 0; n < 40 && !cfg_ready; n++) begin
            frame_sync = n[0];
            if (n == 14) cfg_valid = 1'b0;
            tick();
            if (!cfg_ready) lowcnt++;
        end
        cfg_valid  = 1'b0;
        frame_sync = 1'b0;
        chk("clear_len", 64'(lowcnt), 64'd16);
        chk("clear_keeps_active", 64'(sel_flat[15:12]), 64'd9);
        cmd(2'b01, 4'd0, 4'd0, 1'b1);
        chk("clear_identity", sel_flat, 64'hFEDC_BA98_7654_3210);

        // Reserved op has no effect
        cmd(2'b11, 4'd4, 4'd4, 1'b1);

        // Reset in the middle of a commit wait
        cmd(2'b00, 4'd5, 4'd2, 1'b0);
        cmd(2'b01, 4'd0, 4'd0, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_sel", sel_flat, 64'hFEDC_BA98_7654_3210);
        chk("async_rst_ready", 64'(cfg_ready), 64'd1);
        chk("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("rst_no_done", 64'(commit_done), 64'd0);
        tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cfg_valid  = ($urandom_range(0, 3) != 0);
            cfg_op     = 2'($urandom_range(0, 9) < 6 ? 0 : $urandom_range(1, 3));
            cfg_out    = 4'($urandom_range(0, 15));
            cfg_in     = 4'($urandom_range(0, 15));
            frame_sync = ($urandom_range(0, 4) == 0);
            tick();
        end
        cfg_valid  = 1'b0;
        frame_sync = 1'b0;
        tick();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
